// File: rtl/store_splitter.sv
// rtl/store_splitter.sv - splits a 1/2/4-byte store at any address into one or two word-aligned strobed bus writes
module store_splitter #(
    parameter  int N    = 5,
    localparam int XLEN = 2 ** N,
    localparam int W    = 2 ** (N - 3)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_data,
    input  logic [1:0]      req_size,
    output logic            bus_valid,
    input  logic            bus_ready,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_wdata,
    output logic [W-1:0]    bus_strb,
    output logic            split,
    output logic            done
);
    localparam int OW = N - 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT0 = 2'd1,
        S_BEAT1 = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_req_ready;
    logic                r_bus_valid;
    logic [XLEN-1:0]     r_bus_addr;
    logic [XLEN-1:0]     r_bus_wdata;
    logic [W-1:0]        r_bus_strb;
    logic                r_split;
    logic                r_done;
    logic [XLEN-1:0]     r_hi_data;
    logic [W-1:0]        r_hi_strb;

    state_t              w_state_n;
    logic                w_req_ready_n;
    logic                w_bus_valid_n;
    logic [XLEN-1:0]     w_bus_addr_n;
    logic [XLEN-1:0]     w_bus_wdata_n;
    logic [W-1:0]        w_bus_strb_n;
    logic                w_split_n;
    logic                w_done_n;
    logic [XLEN-1:0]     w_hi_data_n;
    logic [W-1:0]        w_hi_strb_n;

    logic [OW-1:0]       w_off;
    logic [XLEN-1:0]     w_base;
    logic [W-1:0]        w_len_mask;
    logic [XLEN-1:0]     w_data_masked;
    logic [2*W-1:0]      w_mask2;
    logic [2*XLEN-1:0]   w_funnel;
    logic                w_accept;

    assign w_off    = req_addr[OW-1:0];
    assign w_base   = {req_addr[XLEN-1:OW], {OW{1'b0}}};
    assign w_accept = req_valid && r_req_ready;

    // Byte-length mask and size-masked data; sizes wider than a word saturate at W bytes
    always_comb begin
        w_len_mask    = '0;
        w_data_masked = '0;
        for (int i = 0; i < W; i++) begin
            w_len_mask[i] = (i < (1 << req_size));
            w_data_masked[8*i +: 8] = w_len_mask[i] ? req_data[8*i +: 8] : 8'h00;
        end
    end

    // Place mask and data into the two-word funnel at the byte offset
    always_comb begin
        w_mask2  = {{W{1'b0}}, w_len_mask} << w_off;
        w_funnel = {{XLEN{1'b0}}, w_data_masked} << {w_off, 3'b000};
    end

    // Next-state and next-output decode; every output is registered below
    always_comb begin
        w_state_n     = r_state;
        w_req_ready_n = r_req_ready;
        w_bus_valid_n = r_bus_valid;
        w_bus_addr_n  = r_bus_addr;
        w_bus_wdata_n = r_bus_wdata;
        w_bus_strb_n  = r_bus_strb;
        w_split_n     = r_split;
        w_done_n      = 1'b0;
        w_hi_data_n   = r_hi_data;
        w_hi_strb_n   = r_hi_strb;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_n     = S_BEAT0;
                    w_req_ready_n = 1'b0;
                    w_bus_valid_n = 1'b1;
                    w_bus_addr_n  = w_base;
                    w_bus_wdata_n = w_funnel[XLEN-1:0];
                    w_bus_strb_n  = w_mask2[W-1:0];
                    w_hi_data_n   = w_funnel[2*XLEN-1:XLEN];
                    w_hi_strb_n   = w_mask2[2*W-1:W];
                    w_split_n     = |w_mask2[2*W-1:W];
                end
            end
            S_BEAT0: begin
                if (bus_ready) begin
                    if (r_split) begin
                        w_state_n     = S_BEAT1;
                        w_bus_addr_n  = r_bus_addr + XLEN'(W);
                        w_bus_wdata_n = r_hi_data;
                        w_bus_strb_n  = r_hi_strb;
                    end else begin
                        w_state_n     = S_IDLE;
                        w_req_ready_n = 1'b1;
                        w_bus_valid_n = 1'b0;
                        w_bus_addr_n  = '0;
                        w_bus_wdata_n = '0;
                        w_bus_strb_n  = '0;
                        w_done_n      = 1'b1;
                    end
                end
            end
            S_BEAT1: begin
                if (bus_ready) begin
                    w_state_n     = S_IDLE;
                    w_req_ready_n = 1'b1;
                    w_bus_valid_n = 1'b0;
                    w_bus_addr_n  = '0;
                    w_bus_wdata_n = '0;
                    w_bus_strb_n  = '0;
                    w_done_n      = 1'b1;
                end
            end
            default: begin
                w_state_n     = S_IDLE;
                w_req_ready_n = 1'b1;
                w_bus_valid_n = 1'b0;
                w_bus_addr_n  = '0;
                w_bus_wdata_n = '0;
                w_bus_strb_n  = '0;
            end
        endcase
    end

    // State and output registers; reset aborts any in-flight request silently
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_bus_valid <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_strb  <= '0;
            r_split     <= 1'b0;
            r_done      <= 1'b0;
            r_hi_data   <= '0;
            r_hi_strb   <= '0;
        end else begin
            r_state     <= w_state_n;
            r_req_ready <= w_req_ready_n;
            r_bus_valid <= w_bus_valid_n;
            r_bus_addr  <= w_bus_addr_n;
            r_bus_wdata <= w_bus_wdata_n;
            r_bus_strb  <= w_bus_strb_n;
            r_split     <= w_split_n;
            r_done      <= w_done_n;
            r_hi_data   <= w_hi_data_n;
            r_hi_strb   <= w_hi_strb_n;
        end
    end

    assign req_ready = r_req_ready;
    assign bus_valid = r_bus_valid;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign bus_strb  = r_bus_strb;
    assign split     = r_split;
    assign done      = r_done;

endmodule

// File: tb/tb_store_splitter.sv
// tb/tb_store_splitter.sv - randomized self-checking bench for store_splitter against a byte-level store model
module tb_store_splitter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [1:0]  req_size = '0;
    logic        bus_valid;
    logic        bus_ready = 1'b0;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_strb;
    logic        split;
    logic        done;

    int n_checks = 0;
    int n_pass   = 0;

    int          m_n;
    logic [31:0] m_addr [2];
    logic [3:0]  m_strb [2];
    logic [31:0] m_data [2];

    store_splitter #(.N(5)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .bus_valid(bus_valid), .bus_ready(bus_ready),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_strb(bus_strb),
        .split(split), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Byte-by-byte reference: each stored byte lands at its own address in whichever word holds it
    task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        int nb;
        logic [31:0] b0, ba;
        int wi, lane;
        nb = 1 << s;
        if (nb > 4) nb = 4;
        b0 = a & ~32'h3;
        m_addr[0] = b0;
        m_addr[1] = b0 + 32'd4;
        m_strb[0] = '0; m_strb[1] = '0;
        m_data[0] = '0; m_data[1] = '0;
        for (int i = 0; i < nb; i++) begin
            ba   = a + 32'(i);
            wi   = ((ba & ~32'h3) == b0) ? 0 : 1;
            lane = int'(ba[1:0]);
            m_strb[wi][lane] = 1'b1;
            m_data[wi][8*lane +: 8] = d[8*i +: 8];
        end
        m_n = (m_strb[1] != 0) ? 2 : 1;
    endtask

    // Issue one request at a negedge and follow it to done, checking every beat cycle against the model
    task automatic run_req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                           input int st0, input int st1, input bit rnd, input bit hold_v);
        int  beat = 0;
        int  sc = 0;
        int  cyc = 0;
        bit  want_valid = 1'b1;
        bit  fin = 1'b0;
        bit  go;
        model(a, d, s);
        check("ready_idle", req_ready, 1);
        req_valid = 1'b1; req_addr = a; req_data = d; req_size = s;
        @(negedge clk);
        if (!hold_v) req_valid = 1'b0;
        else begin req_addr = $urandom; req_data = $urandom; end
        check("split_on_accept", split, (m_n == 2));
        while (!fin && cyc < 64) begin
            if (want_valid) check("beat_valid", bus_valid, 1);
            want_valid = 1'b0;
            check("ready_busy", req_ready, 0);
            check("done_busy", done, 0);
            if (bus_valid && beat < m_n) begin
                check("bus_addr", bus_addr, m_addr[beat]);
                check("bus_strb", bus_strb, m_strb[beat]);
                check("bus_wdata", bus_wdata, m_data[beat]);
                go = rnd ? ($urandom_range(0, 3) != 0) : (sc >= ((beat == 0) ? st0 : st1));
                bus_ready = go;
                if (go) begin
                    if (beat == m_n - 1) begin
                        fin = 1'b1;
                        if (hold_v) req_valid = 1'b0;
                    end else want_valid = 1'b1;
                    beat++;
                    sc = 0;
                end else sc++;
            end else bus_ready = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check("finished_in_time", fin, 1);
        bus_ready = 1'b0;
        check("beats", beat, m_n);
        check("done_pulse", done, 1);
        check("valid_after", bus_valid, 0);
        check("ready_after", req_ready, 1);
        check("split_final", split, (m_n == 2));
        @(negedge clk);
        check("done_once", done, 0);
        check("split_hold", split, (m_n == 2));
    endtask

    initial begin
        logic [31:0] a, d;
        logic [7:0]  b0, b1;
        repeat (2) @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_valid", bus_valid, 0);
        check("rst_addr", bus_addr, 0);
        check("rst_wdata", bus_wdata, 0);
        check("rst_strb", bus_strb, 0);
        check("rst_split", split, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        @(negedge clk);

        run_req(32'h100, 32'hDEADBEEF, 2'd2, 0, 0, 1'b0, 1'b0);
        run_req(32'h103, 32'h11223344, 2'd2, 0, 0, 1'b0, 1'b0);
        run_req(32'h1FF, 32'h1234ABCD, 2'd1, 0, 0, 1'b0, 1'b0);
        run_req(32'h103, 32'h55667788, 2'd2, 3, 2, 1'b0, 1'b1);
        run_req(32'hFFFFFFFE, 32'hCAFEF00D, 2'd2, 0, 0, 1'b0, 1'b0);
        run_req(32'h203, 32'hA5A5A5A5, 2'd0, 0, 0, 1'b0, 1'b0);
        run_req(32'h302, 32'h99887766, 2'd3, 0, 0, 1'b0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'hFFFFFFFC | 32'($urandom_range(0, 3));
            d = $urandom;
            run_req(a, d, 2'($urandom_range(0, 3)), 0, 0, 1'b1, 1'($urandom_range(0, 1)));
        end

        // Reset while beat 1 is stalled
        req_valid = 1'b1; req_addr = 32'h103; req_data = 32'h11223344; req_size = 2'd2;
        @(negedge clk);
        req_valid = 1'b0;
        bus_ready = 1'b1;
        @(negedge clk);
        bus_ready = 1'b0;
        check("rb_beat1_addr", bus_addr, 32'h104);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rb_valid", bus_valid, 0);
        check("rb_ready", req_ready, 1);
        check("rb_done", done, 0);
        check("rb_strb", bus_strb, 0);
        check("rb_split", split, 0);
        bus_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rb_no_done", done, 0);
            check("rb_no_valid", bus_valid, 0);
        end

        // Back-to-back aligned byte stores: second accepted in the cycle of the first done
        b0 = 8'($urandom); b1 = 8'($urandom);
        req_valid = 1'b1; req_addr = 32'h0; req_data = {24'hFFFFFF, b0}; req_size = 2'd0;
        @(negedge clk);
        req_addr = 32'h5; req_data = {24'hEEEEEE, b1};
        check("bb0_valid", bus_valid, 1);
        check("bb0_addr", bus_addr, 32'h0);
        check("bb0_strb", bus_strb, 4'b0001);
        check("bb0_wdata", bus_wdata, {24'h0, b0});
        @(negedge clk);
        check("bb0_done", done, 1);
        check("bb0_ready", req_ready, 1);
        check("bb0_gap", bus_valid, 0);
        @(negedge clk);
        req_valid = 1'b0;
        check("bb1_valid", bus_valid, 1);
        check("bb1_addr", bus_addr, 32'h4);
        check("bb1_strb", bus_strb, 4'b0010);
        check("bb1_wdata", bus_wdata, {16'h0, b1, 8'h0});
        @(negedge clk);
        check("bb1_done", done, 1);
        check("bb1_split", split, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/store_splitter.md
# store_splitter

Write-side companion of the ALU funnel shifter. The funnel shifter extracts a word window from two concatenated words on the load path; this block takes a store of 1, 2 or 4 bytes at any byte address and produces one or two word-aligned bus writes with byte strobes. It sits between the LSU store issue and the data-memory write port. It sequences the two beats of a word-crossing store with a valid/ready handshake on both sides.

## Interface
Parameters:
- N, default 5: log2 of the data width. XLEN = 2**N; W = 2**(N-3) bytes per word.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  store request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_addr  in  XLEN  byte address, any alignment.
- req_data  in  XLEN  store data, LSB-aligned; bytes above the size are ignored.
- req_size  in  2  0 = byte, 1 = half, 2 = word; codes giving more than W bytes are treated as W bytes.
- bus_valid  out  1  write beat present.
- bus_ready  in  1  memory accepts the beat.
- bus_addr  out  XLEN  word-aligned beat address; low N-3 bits always 0.
- bus_wdata  out  XLEN  beat data; bytes with strobe 0 are driven 0.
- bus_strb  out  W  byte enables.
- split  out  1  the current or last request needed two beats.
- done  out  1  one-cycle pulse: the request's final beat was accepted.

## Operation
- Latch on accept (req_valid && req_ready at the edge):
  - off = req_addr[N-4:0].
  - base = req_addr with the low N-3 bits cleared.
  - The byte mask is ((1 << 2**size) - 1) in 2W bits, shifted left by off.
  - Size-masked data is placed in a 2·XLEN funnel and shifted left by 8·off.
  - Low half of the funnel is beat 0; high half is beat 1.
- split = (high mask half != 0).
- States:
  - IDLE: req_ready = 1. On accept, go to BEAT0.
  - BEAT0: drive base, low data, low mask. On bus handshake, go to BEAT1 if split, else to IDLE with done.
  - BEAT1: drive base + W, high data, high mask. On bus handshake, go to IDLE with done.
- Address arithmetic is modulo 2**XLEN, so base + W wraps to 0 at the top of the space.
- A request is never dropped or reordered.
- Beat 0 always carries at least one strobe, including for a byte store at offset W-1.

## Timing
- Reset values:
  - state IDLE; req_ready 1.
  - bus_valid 0, bus_addr 0, bus_wdata 0, bus_strb 0.
  - split 0, done 0.
- All outputs are registered; none depends combinationally on req_* or bus_ready.
- Request accepted at edge t: bus_valid = 1 from cycle t+1 with beat 0.
- Beat hold: while bus_valid && !bus_ready, bus_addr, bus_wdata and bus_strb hold stable.
- Beat advance: a beat-0 handshake at an edge presents beat 1 in the next cycle. There is no bubble between beats.
- Final handshake at edge e:
  - cycle e+1: bus_valid = 0, done = 1, req_ready = 1.
  - A request accepted at edge e+1 drives bus_valid in cycle e+2.
- Throughput:
  - Aligned or non-crossing store: one request per 2 cycles.
  - Crossing store: one request per 3 cycles with bus_ready held high.
- split is updated on accept and holds until the next accept.
- req_ready is low in BEAT0 and BEAT1; req_valid asserted there is ignored until IDLE.
- Reset asserted in any state:
  - The next cycle shows reset values.
  - No further beats are issued and done does not pulse for the aborted request.
  - A beat already accepted by memory is not retracted.

## Test plan
All cases use N=5 and bus_ready=1 unless stated otherwise.
- Aligned word: addr 0x100, data 0xDEADBEEF, size 2 -> one beat: addr 0x100, strb 1111, wdata 0xDEADBEEF. split=0; done two cycles after accept.
- Crossing word: addr 0x103, data 0x11223344 ->
  - beat 0: addr 0x100, strb 1000, wdata 0x44000000.
  - beat 1: addr 0x104, strb 0111, wdata 0x00112233.
  - split=1; beats in consecutive cycles.
- Crossing half with junk upper bits: addr 0x1FF, data 0x1234ABCD, size 1 ->
  - beat 0: 0x1FC, strb 1000, wdata 0xCD000000.
  - beat 1: 0x200, strb 0001, wdata 0x000000AB.
- Backpressure: crossing store with bus_ready low for 3 cycles on beat 0 and 2 cycles on beat 1 ->
  - beat outputs stable throughout each stall.
  - req_ready stays 0 despite req_valid=1.
  - exactly one done pulse.
- Wrap: addr 0xFFFFFFFE, data 0xCAFEF00D, size 2 ->
  - beat 0: 0xFFFFFFFC, strb 1100, wdata 0xF00D0000.
  - beat 1: 0x00000000, strb 0011, wdata 0x0000CAFE.
- Reset in BEAT1 (bus_ready low), then back-to-back aligned byte stores (0x0 then 0x5) ->
  - After reset: bus_valid=0, req_ready=1, no done.
  - Byte 0x0: strb 0001; byte 0x5: strb 0010 at addr 0x4.
  - Second request accepted in the same cycle as the first done.
